// File: rtl/cache_line_fill_if.sv
// Fill-request and memory-read bundle for cache_line_fill; the slave modport faces the engine.
// Defining CRIT_WORD_FIRST_EN adds the crit_valid/crit_word outputs.
interface cache_line_fill_if #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 16,
    parameter int LINE_W = 64
);
    logic              fill_req;
    logic [ADDR_W-1:0] fill_addr;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_stall;
    logic              mem_rvalid;
    logic [WORD_W-1:0] mem_rdata;
    logic              fill_busy;
    logic              fill_done;
    logic [LINE_W-1:0] line_data;
`ifdef CRIT_WORD_FIRST_EN
    logic              crit_valid;
    logic [WORD_W-1:0] crit_word;
`endif

    modport slave (
        input  fill_req, fill_addr, mem_stall, mem_rvalid, mem_rdata,
`ifdef CRIT_WORD_FIRST_EN
        output crit_valid, crit_word,
`endif
        output mem_rd, mem_addr, fill_busy, fill_done, line_data
    );

    modport master (
        output fill_req, fill_addr, mem_stall, mem_rvalid, mem_rdata,
`ifdef CRIT_WORD_FIRST_EN
        input  crit_valid, crit_word,
`endif
        input  mem_rd, mem_addr, fill_busy, fill_done, line_data
    );
endinterface

// File: rtl/cache_line_fill.sv
// Cache-miss line-fill engine: issues four pipelined word reads and assembles a 64-bit line.
// Optional macro CRIT_WORD_FIRST_EN: critical-word-first ordering plus crit_valid/crit_word.
module cache_line_fill #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 16,
    parameter int NWORDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    cache_line_fill_if.slave bus
);
    localparam int         LINE_W   = NWORDS * WORD_W;
    localparam logic [2:0] CNT_LAST = 3'(NWORDS - 1);
    localparam logic [2:0] CNT_FULL = 3'(NWORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-4:0] r_base;
    logic [1:0]        r_start;
    logic [2:0]        r_icnt;
    logic [2:0]        r_rcnt;
    logic [LINE_W-1:0] r_line;

    logic              w_start;
    logic              w_accept;
    logic              w_resp;
    logic              w_lastAccept;
    logic              w_lastResp;
    logic              w_lineFull;
    logic [1:0]        w_issueIdx;
    logic [1:0]        w_slot;
    logic [1:0]        w_offset;
    logic              w_unused;

`ifdef CRIT_WORD_FIRST_EN
    logic              r_critValid;
    logic [WORD_W-1:0] r_critWord;

    assign w_offset = bus.fill_addr[2:1];
`else
    assign w_offset = 2'b00;
`endif

    // Byte-select bit (and the offset bits when critical-word-first is off) are intentionally dropped.
    assign w_unused = &{1'b0, bus.fill_addr[2:0]};

    assign w_start      = (r_state == S_IDLE) && bus.fill_req;
    assign w_accept     = (r_state == S_ISSUE) && !bus.mem_stall;
    assign w_resp       = ((r_state == S_ISSUE) || (r_state == S_DRAIN))
                          && bus.mem_rvalid && (r_rcnt != CNT_FULL);
    assign w_lastAccept = w_accept && (r_icnt == CNT_LAST);
    assign w_lastResp   = w_resp && (r_rcnt == CNT_LAST);
    assign w_lineFull   = w_lastResp || (r_rcnt == CNT_FULL);
    assign w_issueIdx   = r_start + r_icnt[1:0];
    assign w_slot       = r_start + r_rcnt[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        bus.mem_rd    = 1'b0;
        bus.mem_addr  = '0;
        bus.fill_busy = 1'b0;
        bus.fill_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.fill_req) begin
                    w_nextState = S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus.mem_rd    = 1'b1;
                bus.mem_addr  = {r_base, w_issueIdx, 1'b0};
                bus.fill_busy = 1'b1;
                // A final response landing with the final acceptance skips DRAIN entirely.
                if (w_lastAccept) begin
                    w_nextState = w_lineFull ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                bus.fill_busy = 1'b1;
                if (w_lineFull) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                bus.fill_done = 1'b1;
                w_nextState   = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base  <= '0;
            r_start <= '0;
            r_icnt  <= '0;
            r_rcnt  <= '0;
            r_line  <= '0;
        end else begin
            if (w_start) begin
                r_base  <= bus.fill_addr[ADDR_W-1:3];
                r_start <= w_offset;
                r_icnt  <= '0;
                r_rcnt  <= '0;
            end
            if (w_accept) begin
                r_icnt <= r_icnt + 3'd1;
            end
            // Unwritten slots keep the previous line's words until overwritten.
            if (w_resp) begin
                r_rcnt <= r_rcnt + 3'd1;
                for (int k = 0; k < NWORDS; k++) begin
                    if (w_slot == 2'(k)) begin
                        r_line[k*WORD_W +: WORD_W] <= bus.mem_rdata;
                    end
                end
            end
        end
    end

    assign bus.line_data = r_line;

`ifdef CRIT_WORD_FIRST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_critValid <= 1'b0;
            r_critWord  <= '0;
        end else begin
            r_critValid <= w_resp && (r_rcnt == 3'd0);
            if (w_resp && (r_rcnt == 3'd0)) begin
                r_critWord <= bus.mem_rdata;
            end
        end
    end

    assign bus.crit_valid = r_critValid;
    assign bus.crit_word  = r_critWord;
`endif
endmodule

// File: doc/cache_line_fill.md
Name: cache_line_fill

Overview:
- Cache-miss line-fill engine. Fetches four 16-bit words from memory and assembles them into one 64-bit line.
- Word k of the line sits at bits [16k+15:16k].
- The completed line feeds the 4-to-1 64-bit line select mux (cache way / fill / victim / bypass select) directly downstream.
- Issues pipelined read requests with a stall handshake and collects in-order responses.

Parameters:
- WORD_W, 16, width of one memory word.
- ADDR_W, 16, byte address width.
- NWORDS, 4, words per line; fixed at 4 (line = 64 bits). Other values are unsupported.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- fill_req  in  1  start a line fill. Sampled only in IDLE.
- fill_addr  in  ADDR_W  miss address. Bits [2:1] = word offset; bit 0 ignored.
- mem_rd  out  1  read request valid.
- mem_addr  out  ADDR_W  read address, always word-aligned (bit 0 = 0).
- mem_stall  in  1  memory cannot accept this cycle's request; request must be held.
- mem_rvalid  in  1  read response valid. Responses return in request order.
- mem_rdata  in  WORD_W  read response data.
- fill_busy  out  1  high in ISSUE and DRAIN.
- fill_done  out  1  one-cycle pulse when the line is complete.
- line_data  out  64  assembled line. Held stable from fill_done until the next accepted fill_req.

Behaviour:
- Reset: state=IDLE; mem_rd=0; mem_addr=0; fill_busy=0; fill_done=0; line_data=0; counters=0.
- rst has priority over all other inputs.
- Reset mid-fill aborts immediately. No further requests are issued. Late mem_rvalid responses are ignored, since IDLE ignores mem_rvalid.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - fill_req=1 latches base = {fill_addr[ADDR_W-1:3],3'b000} and start offset.
  - Clears issue count (icnt) and response count (rcnt).
  - Goes to ISSUE next cycle.
- ISSUE:
  - mem_rd=1.
  - mem_addr = base | (word index << 1), with word index = (start + icnt) mod 4.
  - Request is accepted in any cycle with mem_rd=1 and mem_stall=0; icnt then increments.
  - While mem_stall=1, mem_addr is held unchanged.
  - After the 4th accepted request, go to DRAIN. mem_rd=0 from that cycle.
- DRAIN: wait until rcnt reaches 4.
- Responses (ISSUE or DRAIN):
  - Each mem_rvalid writes mem_rdata into line slot (start + rcnt) mod 4; rcnt increments.
  - A response may arrive in the same cycle as its request's acceptance or later; latency is arbitrary (>=0 cycles after acceptance).
  - mem_rvalid with rcnt already at 4 is a protocol error and is ignored.
- Completion:
  - When the 4th response is written, go to DONE next cycle.
  - If the 4th response arrives in ISSUE, in the same cycle as the 4th acceptance, go directly to DONE.
- DONE: fill_done=1 for exactly one cycle, then IDLE. fill_req in DONE is ignored.
- fill_req while fill_busy=1 is ignored; no queueing.
- Without CRIT_WORD_FIRST_EN, start offset is forced to 0.
- Minimum latency, with no stalls and 0-cycle response: fill_req at cycle 0; requests in cycles 1-4; fill_done in cycle 5.
- Words in line_data not yet written during a fill keep their previous-line values. Only the full line is valid at fill_done.

Optional Feature:
- Macro CRIT_WORD_FIRST_EN.
- Defined:
  - Start offset = fill_addr[2:1].
  - Requests wrap: off, off+1, ..., mod 4.
  - Adds output crit_valid (1 bit): one-cycle pulse in the cycle the first response is written.
  - Adds output crit_word (WORD_W): registered copy of that first word, valid with crit_valid and held until the next fill.
- Undefined: requests always start at word 0; crit_valid and crit_word ports are absent.

Test Plan:
- Basic fill:
  - Stimulus: fill_addr=0x1230, no stall, 1-cycle response latency, data 0xAAAA, 0xBBBB, 0xCCCC, 0xDDDD.
  - Required: mem_addr sequence 0x1230, 0x1232, 0x1234, 0x1236; fill_done once; line_data=0xDDDDCCCCBBBBAAAA.
- Stall hold:
  - Stimulus: mem_stall=1 for 3 cycles on the 2nd request.
  - Required: mem_addr held at 0x1232 with mem_rd=1 for those 3 cycles; exactly 4 accepted requests; fill_done delayed 3 cycles.
- Ignored requests:
  - Stimulus: fill_req pulses during ISSUE, DRAIN and DONE.
  - Required: no new fill; base unchanged; single fill_done.
- Reset mid-fill:
  - Stimulus: rst after 2 responses; then mem_rvalid asserted 2 more times.
  - Required: all outputs at reset values next cycle; line_data=0; no fill_done.
  - Follow-up: a new fill completes normally.
- Critical word (CRIT_WORD_FIRST_EN):
  - Stimulus: fill_addr=0x00A4 (offset 2), data W2, W3, W0, W1 = 0x2222, 0x3333, 0x0000, 0x1111.
  - Required: addresses 0x00A4, 0x00A6, 0x00A0, 0x00A2; crit_valid with crit_word=0x2222; line_data=0x3333222211110000.
- Zero latency:
  - Stimulus: mem_rvalid in the same cycle as each acceptance, no stalls.
  - Required: fill_done exactly 5 cycles after fill_req.
